// File: rtl/crop_job_sequencer.sv
// Job sequencer for the crop flow: parses and validates the BMP header, then runs
// the bounding-box engine and the writer in turn. Optional watchdog: CROP_TIMEOUT_EN.
module crop_job_sequencer #(
    parameter int ADDR_W         = 16,
    parameter int DIM_W          = 12,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [DIM_W-1:0]  img_width,
    output logic [DIM_W-1:0]  img_height,
    output logic [ADDR_W-1:0] data_offset,
    output logic [ADDR_W-1:0] row_stride,
    output logic              bbox_start,
    input  logic              bbox_done,
    output logic              wr_start,
    input  logic              wr_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SW = ADDR_W + 2;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        CHECK,
        BBOX_GO,
        BBOX_WAIT,
        WR_GO,
        WR_WAIT,
        DONE,
        ERR
    } state_t;

    state_t state, next_state;

    logic [4:0]    k;
    logic [4:0]    byte_idx;
    logic [15:0]   sig;
    logic [31:0]   offset_f;
    logic [31:0]   width_f;
    logic [31:0]   height_f;
    logic [15:0]   bpp;
    logic [SW-1:0] stride_full;
    logic          header_ok;
    logic          wd_expired;
    logic [31:0]   wd_count;

    // Row bytes padded up to a multiple of four, with two guard bits to detect overflow.
    assign stride_full = (SW'(width_f) * SW'(3) + SW'(3)) & ~SW'(3);

    assign header_ok = (sig == 16'h4D42) && (bpp == 16'd24)
                    && (width_f != 32'd0) && (height_f != 32'd0)
                    && ((width_f >> DIM_W) == 32'd0)
                    && ((height_f >> DIM_W) == 32'd0)
                    && ((offset_f >> ADDR_W) == 32'd0)
                    && ((stride_full >> ADDR_W) == SW'(0));

`ifdef CROP_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            wd_count <= 32'd0;
        end else if (state == BBOX_GO || state == WR_GO) begin
            wd_count <= 32'd0;
        end else if (state == BBOX_WAIT || state == WR_WAIT) begin
            wd_count <= wd_count + 32'd1;
        end
    end
`else
    localparam bit WD_EN = 1'b0;

    assign wd_count = 32'd0;
`endif

    // Fires on the last waiting cycle so err rises exactly TIMEOUT_CYCLES after entry.
    assign wd_expired = WD_EN && (wd_count == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (start) next_state = HDR;
            HDR:             if (k == 5'd30) next_state = CHECK;
            CHECK:           next_state = header_ok ? BBOX_GO : ERR;
            BBOX_GO:         next_state = BBOX_WAIT;
            BBOX_WAIT: begin
                if (bbox_done)       next_state = WR_GO;
                else if (wd_expired) next_state = ERR;
            end
            WR_GO:           next_state = WR_WAIT;
            WR_WAIT: begin
                if (wr_done)         next_state = DONE;
                else if (wd_expired) next_state = ERR;
            end
            default:         next_state = IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so cycle k carries header byte k-1.
    assign byte_idx = k - 5'd1;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            k        <= 5'd0;
            sig      <= 16'd0;
            offset_f <= 32'd0;
            width_f  <= 32'd0;
            height_f <= 32'd0;
            bpp      <= 16'd0;
        end else if ((state == IDLE || state == DONE || state == ERR) && start) begin
            k <= 5'd0;
        end else if (state == HDR) begin
            k <= k + 5'd1;
            if (k != 5'd0) begin
                case (byte_idx)
                    5'd0:  sig[7:0]        <= rd_data;
                    5'd1:  sig[15:8]       <= rd_data;
                    5'd10: offset_f[7:0]   <= rd_data;
                    5'd11: offset_f[15:8]  <= rd_data;
                    5'd12: offset_f[23:16] <= rd_data;
                    5'd13: offset_f[31:24] <= rd_data;
                    5'd18: width_f[7:0]    <= rd_data;
                    5'd19: width_f[15:8]   <= rd_data;
                    5'd20: width_f[23:16]  <= rd_data;
                    5'd21: width_f[31:24]  <= rd_data;
                    5'd22: height_f[7:0]   <= rd_data;
                    5'd23: height_f[15:8]  <= rd_data;
                    5'd24: height_f[23:16] <= rd_data;
                    5'd25: height_f[31:24] <= rd_data;
                    5'd28: bpp[7:0]        <= rd_data;
                    5'd29: bpp[15:8]       <= rd_data;
                    default: ;
                endcase
            end
        end
    end

    // Geometry is only published by a header that passed; a rejected one leaves it alone.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            img_width   <= '0;
            img_height  <= '0;
            data_offset <= '0;
            row_stride  <= '0;
        end else if (state == CHECK && header_ok) begin
            img_width   <= width_f[DIM_W-1:0];
            img_height  <= height_f[DIM_W-1:0];
            data_offset <= offset_f[ADDR_W-1:0];
            row_stride  <= stride_full[ADDR_W-1:0];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (next_state == DONE);
            err  <= (next_state == ERR);
        end
    end

    assign rd_addr    = (state == HDR && k < 5'd30) ? ADDR_W'(k) : '0;
    assign bbox_start = (state == BBOX_GO);
    assign wr_start   = (state == WR_GO);
    assign busy       = !(state == IDLE || state == DONE || state == ERR);

endmodule

// File: tb/tb_crop_job_sequencer.sv
// Bench for crop_job_sequencer: directed and random headers checked against a
// plain-arithmetic model of the header rules and job handshake timing.
module tb_crop_job_sequencer;

    localparam int ADDR_W  = 16;
    localparam int DIM_W   = 12;
    localparam int TIMEOUT = 100;

    logic              CLOCK_50 = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [DIM_W-1:0]  img_width;
    logic [DIM_W-1:0]  img_height;
    logic [ADDR_W-1:0] data_offset;
    logic [ADDR_W-1:0] row_stride;
    logic              bbox_start;
    logic              bbox_done;
    logic              wr_start;
    logic              wr_done;
    logic              busy;
    logic              done;
    logic              err;

    logic [7:0]  mem [0:63];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_w, exp_h, exp_off, exp_stride;

    crop_job_sequencer #(
        .ADDR_W(ADDR_W),
        .DIM_W(DIM_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst(rst),
        .start(start),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .img_width(img_width),
        .img_height(img_height),
        .data_offset(data_offset),
        .row_stride(row_stride),
        .bbox_start(bbox_start),
        .bbox_done(bbox_done),
        .wr_start(wr_start),
        .wr_done(wr_done),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) rd_data <= mem[rd_addr[5:0]];

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Header acceptance and padded stride straight from the BMP rules.
    function automatic bit modelValid(input logic [15:0] sig, input logic [31:0] off,
                                      input logic [31:0] w, input logic [31:0] h,
                                      input logic [15:0] bpp, output longint stride);
        longint lw, lh, lo;
        lw = longint'(w);
        lh = longint'(h);
        lo = longint'(off);
        stride = ((lw * 3 + 3) / 4) * 4;
        return (sig == 16'h4D42) && (bpp == 16'd24) && (lw != 0) && (lh != 0)
            && (lw < (longint'(1) << DIM_W)) && (lh < (longint'(1) << DIM_W))
            && (lo < (longint'(1) << ADDR_W)) && (stride < (longint'(1) << ADDR_W));
    endfunction

    task automatic applyStimulus(input logic [15:0] sig, input logic [31:0] off,
                                 input logic [31:0] w, input logic [31:0] h,
                                 input logic [15:0] bpp);
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[0]  = sig[7:0];
        mem[1]  = sig[15:8];
        for (int i = 0; i < 4; i++) begin
            mem[10 + i] = off[8*i +: 8];
            mem[18 + i] = w[8*i +: 8];
            mem[22 + i] = h[8*i +: 8];
        end
        mem[28] = bpp[7:0];
        mem[29] = bpp[15:8];
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("start_clears_done", done, 0);
        checkOutput("start_clears_err", err, 0);
        checkOutput("busy_in_hdr", busy, 1);
    endtask

    task automatic runJob(input logic [15:0] sig, input logic [31:0] off,
                          input logic [31:0] w, input logic [31:0] h,
                          input logic [15:0] bpp, input bit poke, input bit sweep);
        bit     ok;
        longint st;
        logic   saw_go;
        int     n;
        ok = modelValid(sig, off, w, h, bpp, st);
        applyStimulus(sig, off, w, h, bpp);
        saw_go = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (sweep) checkOutput("rd_addr_sweep", 32'(rd_addr), (c <= 30) ? c - 1 : 0);
            saw_go = saw_go | bbox_start | wr_start;
            start = poke && (c == 10);
            step();
        end
        start = 1'b0;
        checkOutput("no_go_before_33", saw_go, 0);
        if (ok) begin
            exp_w = w; exp_h = h; exp_off = off; exp_stride = 32'(st);
        end
        checkOutput("bbox_start_c33", bbox_start, ok);
        checkOutput("err_after_check", err, !ok);
        checkOutput("busy_after_check", busy, ok);
        checkOutput("img_width", 32'(img_width), exp_w);
        checkOutput("img_height", 32'(img_height), exp_h);
        checkOutput("data_offset", 32'(data_offset), exp_off);
        checkOutput("row_stride", 32'(row_stride), exp_stride);
        if (!ok) begin
            step();
            step();
            checkOutput("err_no_bbox_start", bbox_start, 0);
            checkOutput("err_no_wr_start", wr_start, 0);
            checkOutput("err_held", err, 1);
            checkOutput("err_not_done", done, 0);
            return;
        end
        bbox_done = poke;
        step();
        bbox_done = 1'b0;
        checkOutput("bbox_start_one_cycle", bbox_start, 0);
        checkOutput("early_done_ignored", wr_start, 0);
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
            start = poke && (i == 0);
            step();
        end
        start = 1'b0;
        checkOutput("bbox_wait_busy", busy, 1);
        checkOutput("bbox_wait_no_wr", wr_start, 0);
        bbox_done = 1'b1;
        step();
        bbox_done = 1'b0;
        checkOutput("wr_start", wr_start, 1);
        step();
        checkOutput("wr_start_one_cycle", wr_start, 0);
        if (poke) begin
            bbox_done = 1'b1;
            step();
            bbox_done = 1'b0;
            checkOutput("stray_bbox_done_busy", busy, 1);
            checkOutput("stray_bbox_done_no_done", done, 0);
        end
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        checkOutput("job_done", done, 1);
        checkOutput("job_not_busy", busy, 0);
        checkOutput("job_no_err", err, 0);
    endtask

    // Runs a standard 40x30 job up to its first BBOX_WAIT cycle.
    task automatic startToWait();
        applyStimulus(16'h4D42, 32'd54, 32'd40, 32'd30, 16'd24);
        repeat (33) step();
        exp_w = 32'd40; exp_h = 32'd30; exp_off = 32'd54; exp_stride = 32'd120;
        checkOutput("in_bbox_wait_busy", busy, 1);
        checkOutput("in_bbox_wait_no_go", bbox_start, 0);
    endtask

    initial begin
        logic [15:0] sig, bpp;
        logic [31:0] off, w, h;
        int          mode;

        rst = 1'b1; start = 1'b0; bbox_done = 1'b0; wr_done = 1'b0;
        exp_w = 0; exp_h = 0; exp_off = 0; exp_stride = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'd0;
        repeat (3) step();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_rd_addr", 32'(rd_addr), 0);
        checkOutput("reset_width", 32'(img_width), 0);
        rst = 1'b0;
        step();

        runJob(16'h4D42, 32'd54, 32'd40, 32'd30, 16'd24, 1'b0, 1'b1);
        checkOutput("stride_40", 32'(row_stride), 120);
        runJob(16'h4D42, 32'd54, 32'd25, 32'd7, 16'd24, 1'b0, 1'b0);
        checkOutput("stride_25", 32'(row_stride), 76);
        runJob(16'h4D42, 32'd54, 32'd1, 32'd1, 16'd24, 1'b0, 1'b0);
        checkOutput("stride_1", 32'(row_stride), 4);

        runJob(16'h4E42, 32'd54, 32'd40, 32'd30, 16'd24, 1'b0, 1'b0);
        runJob(16'h4D42, 32'd54, 32'd40, 32'd30, 16'd8, 1'b0, 1'b0);
        runJob(16'h4D42, 32'd54, 32'd40, 32'hFFFFFFE2, 16'd24, 1'b0, 1'b0);
        runJob(16'h4D42, 32'd54, 32'd4095, 32'd4095, 16'd24, 1'b0, 1'b0);
        runJob(16'h4D42, 32'd54, 32'd4096, 32'd30, 16'd24, 1'b0, 1'b0);
        runJob(16'h4D42, 32'h0001_0000, 32'd40, 32'd30, 16'd24, 1'b0, 1'b0);
        runJob(16'h4D42, 32'h0000_FFFF, 32'd40, 32'd30, 16'd24, 1'b1, 1'b0);

        startToWait();
        step();
        step();
        rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_width", 32'(img_width), 0);
        checkOutput("async_rst_stride", 32'(row_stride), 0);
        checkOutput("async_rst_done", done, 0);
        checkOutput("async_rst_err", err, 0);
        exp_w = 0; exp_h = 0; exp_off = 0; exp_stride = 0;
        step();
        rst = 1'b0;
        step();
        runJob(16'h4D42, 32'd54, 32'd40, 32'd30, 16'd24, 1'b0, 1'b1);

        startToWait();
`ifdef CROP_TIMEOUT_EN
        repeat (TIMEOUT - 1) step();
        checkOutput("timeout_not_early", err, 0);
        checkOutput("timeout_busy", busy, 1);
        step();
        checkOutput("timeout_err", err, 1);
        checkOutput("timeout_idle", busy, 0);
`else
        repeat (150) step();
        checkOutput("no_timeout_busy", busy, 1);
        checkOutput("no_timeout_err", err, 0);
        bbox_done = 1'b1;
        step();
        bbox_done = 1'b0;
        checkOutput("late_wr_start", wr_start, 1);
        step();
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        checkOutput("late_done", done, 1);
`endif

        for (int j = 0; j < 12; j++) begin
            sig = 16'h4D42; bpp = 16'd24;
            w = 32'($urandom_range(1, 4095));
            h = 32'($urandom_range(1, 4095));
            off = 32'($urandom_range(14, 1000));
            mode = $urandom_range(0, 9);
            case (mode)
                0: sig = 16'($urandom);
                1: bpp = 16'($urandom_range(0, 32));
                2: w = 32'd0;
                3: h = $urandom;
                4: off = $urandom;
                5: w = 32'($urandom_range(4096, 70000));
                default: ;
            endcase
            runJob(sig, off, w, h, bpp, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crop_job_sequencer.md
Name: crop_job_sequencer

Overview:
Top-level sequencer for the image-cropping flow. On start it parses the BMP header from the read memory, validates it and publishes image geometry. It then runs the bounding-box engine and the cropped-image writer in order, each with a start/done handshake, and reports done or err. It sits in top between readMem, the bounding-box engine and the writeMem writer.

Parameters:
ADDR_W, 16, read-memory byte address width; also the width of data_offset and row_stride
DIM_W, 12, width of img_width/img_height; larger dimensions are errors
TIMEOUT_CYCLES, 2000000, watchdog limit per engine phase (used only with CROP_TIMEOUT_EN)

Ports:
CLOCK_50  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle job request
rd_addr  out  ADDR_W  readMem byte address; synchronous read, data one cycle later
rd_data  in  8  readMem byte
img_width  out  DIM_W  parsed width in pixels
img_height  out  DIM_W  parsed height in pixels
data_offset  out  ADDR_W  pixel-array byte offset (header bytes 10..13)
row_stride  out  ADDR_W  bytes per padded row
bbox_start  out  1  one-cycle pulse to bounding-box engine
bbox_done  in  1  bounding-box engine completion pulse
wr_start  out  1  one-cycle pulse to writer
wr_done  in  1  writer completion pulse
busy  out  1  high in any state except IDLE/DONE/ERR
done  out  1  job complete, held until next start or reset
err  out  1  job failed, held until next start or reset

Behaviour:
- Reset (asynchronous, any state): state IDLE. All outputs 0. Header registers and counters 0.
- States: IDLE, HDR, CHECK, BBOX_GO, BBOX_WAIT, WR_GO, WR_WAIT, DONE, ERR.
- IDLE/DONE/ERR: start=1 clears done and err, resets byte counter k to 0, and moves to HDR. Other inputs are ignored.
- HDR: k counts 0..30, one per cycle.
  - rd_addr=k while k<30; rd_addr is 0 otherwise.
  - When k>=1, rd_data is byte k-1. Capture little-endian fields:
    - bytes 0,1: signature
    - bytes 10-13: offset
    - bytes 18-21: width
    - bytes 22-25: height
    - bytes 28,29: bpp
  - At k=30: capture byte 29, then go to CHECK. HDR lasts exactly 31 cycles.
- CHECK (1 cycle): go to ERR if any of the following holds:
  - signature != 0x4D42 ("BM")
  - bpp != 24
  - width==0 or height==0
  - width or height >= 2^DIM_W; this includes negative (top-down) height, bit 31 set
  - offset >= 2^ADDR_W
  Otherwise register the outputs and go to BBOX_GO:
  - img_width, img_height, data_offset from the parsed fields
  - row_stride = (width*3 + 3) & ~3, computed at ADDR_W+2 bits; err if the result does not fit in ADDR_W
- Geometry outputs hold stable from CHECK exit until the next start. They are unchanged on the ERR path.
- BBOX_GO: bbox_start=1 for exactly one cycle, then BBOX_WAIT.
- BBOX_WAIT: bbox_done=1 moves to WR_GO.
- WR_GO: wr_start=1 for one cycle, then WR_WAIT.
- WR_WAIT: wr_done=1 moves to DONE.
- Timing: with start accepted at cycle 0, bbox_start is high at cycle 33.
- bbox_done/wr_done outside their wait states are ignored. This includes a done coincident with the go pulse.
- start while busy is ignored. There is no queueing.
- done and err are mutually exclusive and registered. Each is set on entry to its state.

Optional Feature:
CROP_TIMEOUT_EN:
- Defined: a 32-bit watchdog clears on entry to BBOX_WAIT and on entry to WR_WAIT, and increments each cycle in those states. Reaching TIMEOUT_CYCLES moves to ERR.
- Undefined: no counter; the wait states block indefinitely.

Test Plan:
1. Valid header (BM, offset 54, 40x30, 24bpp), start -> rd_addr sweeps 0..29. CHECK publishes width 40, height 30, offset 54, stride 120. bbox_start pulses at cycle 33. After bbox_done then wr_done: done=1, busy=0.
2. Width 25 -> row_stride 76. Width 1 -> row_stride 4. Job completes normally.
3. Signature 0x4E42 or bpp 8 or height 0xFFFFFFE2 -> err=1 after CHECK; bbox_start and wr_start never asserted. A new start clears err.
4. Start pulsed during HDR and during BBOX_WAIT -> ignored, and the job sequence is unchanged. bbox_done pulsed in WR_WAIT -> no effect.
5. rst asserted mid-BBOX_WAIT -> same-cycle async clear of all outputs; a fresh start then runs a full job.
6. With CROP_TIMEOUT_EN and TIMEOUT_CYCLES=100, bbox_done withheld -> err=1 exactly 100 cycles after entering BBOX_WAIT. Without the macro -> stays busy.
